// File: rtl/alu_seq.sv
// Sequential 8-bit ALU: single-edge ADD/SUB, 8-cycle shift-add MUL and
// restoring DIV, with a busy/done handshake and divide-by-zero flag.
module alu_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic [7:0] f,
  output logic       err
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_e;

  state_e          r_state;
  op_e             r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    r_rem;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_f;
  logic            r_err;

  logic [W:0]      w_rem_sh;
  logic            w_sub_ok;
  logic [W-1:0]    w_rem_nxt;
  logic [W-1:0]    w_quo_nxt;
  logic [W-1:0]    w_acc_nxt;
  logic            w_last;
  logic            w_fin;
  logic [W-1:0]    w_res;
  logic            w_res_err;

  // One iteration of the shift-add multiplier and the restoring divider.
  // For DIV, r_a doubles as the dividend shifting out and the quotient shifting in.
  always_comb begin
    w_rem_sh  = {r_rem, r_a[W-1]};
    w_sub_ok  = (w_rem_sh >= {1'b0, r_b});
    w_rem_nxt = w_sub_ok ? W'(w_rem_sh - {1'b0, r_b}) : W'(w_rem_sh);
    w_quo_nxt = {r_a[W-2:0], w_sub_ok};
    w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
    w_last    = (r_cnt == CW'(W - 1));
  end

  // Completion decision and result for the current CALC edge.
  always_comb begin
    w_fin     = 1'b0;
    w_res     = '0;
    w_res_err = 1'b0;
    unique case (r_op)
      OP_ADD: begin
        w_fin = 1'b1;
        w_res = r_a + r_b;
      end
      OP_SUB: begin
        w_fin = 1'b1;
        w_res = r_a - r_b;
      end
      OP_MUL: begin
        w_fin = w_last;
        w_res = w_acc_nxt;
      end
      OP_DIV: begin
        if (r_b == '0) begin
          w_fin     = 1'b1;
          w_res     = '1;
          w_res_err = 1'b1;
        end else begin
          w_fin = w_last;
          w_res = w_quo_nxt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_f     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CALC;
            r_op    <= op_e'(op);
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CALC: begin
          if (w_fin) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_f     <= w_res;
            r_err   <= w_res_err;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (r_op == OP_MUL) begin
              r_acc <= w_acc_nxt;
              r_a   <= r_a << 1;
              r_b   <= r_b >> 1;
            end else begin
              r_rem <= w_rem_nxt;
              r_a   <= w_quo_nxt;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign f    = r_f;
  assign err  = r_err;

endmodule
